gray_encoder: RTL and testbench

- Streaming binary-to-Gray encoder; the transmit-side counterpart of the team's Gray-to-binary decoder.
- Accepts binary words over a valid/ready handshake, or generates them from an internal counter.
- Emits registered Gray codes through a 2-entry skid buffer, giving full throughput with a registered in_ready.
- Feeds Gray-coded pointers and position codes to the decoder and to cross-domain logic.

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_encoder_if.sv | 35 +++
 rtl/gray_skid_buf.sv | 80 ++++++++
 rtl/gray_encoder.sv | 112 +++++++++++
 tb/tb_gray_encoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and skid-buffer state type, used by the encoder and decoder.
// Conversion functions operate on up to GRAY_MAX_W bits; callers zero-extend and truncate.
package gray_pkg;

  localparam int GRAY_MAX_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 steps.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    return b;
  endfunction

endpackage

// File: rtl/gray_encoder_if.sv
// Handshake bundle for the Gray encoder: binary input stream and Gray/binary output stream.
// master = producer/consumer side driving the encoder, slave = the encoder itself.
interface gray_encoder_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;

  modport master (
    output in_valid,
    output bin_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  gray_out,
    input  bin_out
  );

  modport slave (
    input  in_valid,
    input  bin_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output gray_out,
    output bin_out
  );

endinterface

// File: rtl/gray_skid_buf.sv
// Two-entry skid buffer with registered in_ready; head entry drives the output directly.
// state | meaning: EMPTY no entry held | ONE head valid | FULL head and tail valid, input stalled
module gray_skid_buf
  import gray_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  skid_state_t   state_q, state_d;
  logic          ready_q;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          accept;
  logic          pop;

  assign accept = in_valid_i && ready_q;
  assign pop    = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = in_data_i;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_data_i;
        end else if (accept) begin
          state_d = FULL;
          tail_d  = in_data_i;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low here, so only a pop can move the buffer.
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q != EMPTY);
    in_ready_o  = ready_q;
    out_data_o  = head_q;
  end

endmodule

// File: rtl/gray_encoder.sv
// Streaming binary-to-Gray encoder fed by bin_in or an internal counter, output via skid buffer.
// Optional step checker on popped counter codes: define GRAY_ENCODER_STEP_CHECK_EN.
module gray_encoder
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CNT_INIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_sel_i,
  input  logic          cnt_clr_i,
  gray_encoder_if.slave bus,
  output logic          step_err_o
);

  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(CNT_INIT);

  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               src_valid;
  logic [WIDTH-1:0]   src_bin;
  logic [WIDTH-1:0]   src_gray;
  logic               buf_ready;
  logic               accept;
  logic [2*WIDTH-1:0] buf_in;
  logic [2*WIDTH-1:0] buf_out;

  // Counter source is always offering; bin_in is ignored while it is selected.
  assign src_valid = src_sel_i ? 1'b1 : bus.in_valid;
  assign src_bin   = src_sel_i ? cnt_q : bus.bin_in;
  assign src_gray  = WIDTH'(bin2gray(GRAY_MAX_W'(src_bin)));
  assign accept    = src_valid && buf_ready;
  assign buf_in    = {src_gray, src_bin};

  assign bus.in_ready = buf_ready && !src_sel_i;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = CNT_RST;
    end else if (accept && src_sel_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  gray_skid_buf #(
    .DW (2 * WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (src_valid),
    .in_ready_o  (buf_ready),
    .in_data_i   (buf_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (buf_out)
  );

  assign bus.gray_out = buf_out[2*WIDTH-1:WIDTH];
  assign bus.bin_out  = buf_out[WIDTH-1:0];

`ifdef GRAY_ENCODER_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             err_q, err_d;
  logic             pop;

  assign pop = bus.out_valid && bus.out_ready;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    err_d      = 1'b0;
    if (pop) begin
      prev_d     = bus.gray_out;
      prev_vld_d = 1'b1;
      // Stream-mode pops only refresh the reference code.
      if (src_sel_i && prev_vld_q && ($countones(prev_q ^ bus.gray_out) != 1)) begin
        err_d = 1'b1;
      end
    end
    if (cnt_clr_i) begin
      prev_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      err_q      <= err_d;
    end
  end

  assign step_err_o = err_q;
`else
  assign step_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_encoder.sv
// Self-checking bench for gray_encoder: two instances (CNT_INIT 0 and 14) share one stimulus,
// each tracked by a capacity-2 FIFO model with its own counter.
module tb_gray_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       src_sel;
  logic       cnt_clr;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] bin_in;
  logic       err0, err14;

  always #5 clk = ~clk;

  gray_encoder_if #(.WIDTH(4)) bus0 ();
  gray_encoder_if #(.WIDTH(4)) bus14 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.bin_in     = bin_in;
  assign bus0.out_ready  = out_ready;
  assign bus14.in_valid  = in_valid;
  assign bus14.bin_in    = bin_in;
  assign bus14.out_ready = out_ready;

  gray_encoder #(.WIDTH(4), .CNT_INIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_sel_i  (src_sel),
    .cnt_clr_i  (cnt_clr),
    .bus        (bus0),
    .step_err_o (err0)
  );

  gray_encoder #(.WIDTH(4), .CNT_INIT(14)) dut14 (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_sel_i  (src_sel),
    .cnt_clr_i  (cnt_clr),
    .bus        (bus14),
    .step_err_o (err14)
  );

  int checks = 0;
  int errors = 0;

  // Model: per instance, a bounded FIFO (depth 2) of binary words plus a counter.
  int qd [2][2];
  int qn [2];
  int cnt [2];
  int init_val [2];

  localparam logic [3:0] EXP_G [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  function automatic int ref_gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int ref_dec(input int g);
    int b;
    b = 0;
    for (int i = 3; i >= 0; i--) begin
      b = b | ((((g >> i) & 1) ^ ((b >> (i + 1)) & 1)) << i);
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      qn[m]  = 0;
      cnt[m] = init_val[m];
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit acc, pop;
      int w;
      acc = (src_sel || in_valid) && (qn[m] < 2);
      pop = (qn[m] > 0) && out_ready;
      w   = src_sel ? cnt[m] : int'(bin_in);
      if (pop) begin
        qd[m][0] = qd[m][1];
        qn[m]    = qn[m] - 1;
      end
      if (acc) begin
        qd[m][qn[m]] = w;
        qn[m]        = qn[m] + 1;
      end
      if (cnt_clr) cnt[m] = init_val[m];
      else if (acc && src_sel) cnt[m] = (cnt[m] + 1) % 16;
    end
  endtask

  task automatic check_cycle();
    for (int m = 0; m < 2; m++) begin
      logic ov, ir, se;
      logic [3:0] go, bo;
      if (m == 0) begin
        ov = bus0.out_valid; ir = bus0.in_ready; se = err0; go = bus0.gray_out; bo = bus0.bin_out;
      end else begin
        ov = bus14.out_valid; ir = bus14.in_ready; se = err14; go = bus14.gray_out; bo = bus14.bin_out;
      end
      checks++;
      if (ov !== (qn[m] > 0)) begin
        errors++;
        $display("FAIL out_valid[%0d] t=%0t: got %b expected %b", m, $time, ov, (qn[m] > 0));
      end
      checks++;
      if (ir !== ((qn[m] < 2) && !src_sel)) begin
        errors++;
        $display("FAIL in_ready[%0d] t=%0t: got %b expected %b", m, $time, ir, ((qn[m] < 2) && !src_sel));
      end
      checks++;
      if (se !== 1'b0) begin
        errors++;
        $display("FAIL step_err[%0d] t=%0t: got %b expected 0", m, $time, se);
      end
      if (qn[m] > 0) begin
        checks++;
        if (int'(go) !== ref_gray(qd[m][0]) || int'(bo) !== qd[m][0]) begin
          errors++;
          $display("FAIL data[%0d] t=%0t: got gray %b bin %0d expected gray %b bin %0d",
                   m, $time, go, bo, 4'(ref_gray(qd[m][0])), qd[m][0]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) src_sel = ~src_sel;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      bin_in    = 4'($urandom);
      cnt_clr   = $urandom_range(0, 15) == 0;
      tick();
    end
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    src_sel  = 1'b0;
  endtask

  task automatic do_reset();
    src_sel   = 1'b0;
    cnt_clr   = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus14.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b/%b expected 0", bus0.out_valid, bus14.out_valid);
    end
    checks++;
    if (bus0.in_ready !== 1'b1 || bus14.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b expected 1", bus0.in_ready, bus14.in_ready);
    end
    checks++;
    if (bus0.gray_out !== 4'd0 || bus0.bin_out !== 4'd0 || bus14.gray_out !== 4'd0 || bus14.bin_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: got %b %b %b %b expected all 0",
               bus0.gray_out, bus0.bin_out, bus14.gray_out, bus14.bin_out);
    end
    checks++;
    if (err0 !== 1'b0 || err14 !== 1'b0) begin
      errors++;
      $display("FAIL reset_step_err: got %b/%b expected 0", err0, err14);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    random_traffic(30);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b0;
  endtask

  task automatic test_stream();
    src_sel   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bin_in = 4'(i);
      tick();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.gray_out !== EXP_G[i]) begin
        errors++;
        $display("FAIL stream_%0d: got valid %b gray %b expected valid 1 gray %b",
                 i, bus0.out_valid, bus0.gray_out, EXP_G[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    src_sel   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    bin_in    = 4'd5;
    tick();
    bin_in = 4'd6;
    tick();
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_drop: got %b expected 0", bus0.in_ready);
    end
    bin_in = 4'd7;
    tick();
    tick();
    checks++;
    if (bus0.gray_out !== 4'b0111 || bus0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got %b valid %b expected 0111 valid 1", bus0.gray_out, bus0.out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (bus0.gray_out !== 4'b0101) begin
      errors++;
      $display("FAIL bp_second: got %b expected 0101", bus0.gray_out);
    end
    tick();
    checks++;
    if (bus0.gray_out !== 4'b0100) begin
      errors++;
      $display("FAIL bp_third: got %b expected 0100", bus0.gray_out);
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    src_sel   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int b;
      b = (14 + i) % 16;
      tick();
      checks++;
      if (bus14.gray_out !== EXP_G[b] || int'(bus14.bin_out) !== b) begin
        errors++;
        $display("FAIL wrap_%0d: got gray %b bin %0d expected gray %b bin %0d",
                 i, bus14.gray_out, bus14.bin_out, EXP_G[b], b);
      end
    end
    src_sel = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_cnt_clr();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    src_sel   = 1'b0;
    cnt_clr   = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick();
    src_sel = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    cnt_clr = 1'b1;
    tick();
    checks++;
    if (bus0.gray_out !== 4'b1101 || bus0.bin_out !== 4'd9) begin
      errors++;
      $display("FAIL clr_pre: got gray %b bin %0d expected 1101 bin 9", bus0.gray_out, bus0.bin_out);
    end
    cnt_clr = 1'b0;
    tick();
    checks++;
    if (bus0.gray_out !== 4'b0000 || bus0.bin_out !== 4'd0) begin
      errors++;
      $display("FAIL clr_post: got gray %b bin %0d expected 0000 bin 0", bus0.gray_out, bus0.bin_out);
    end
    src_sel = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_loopback();
    src_sel   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bin_in = 4'(i);
      tick();
      checks++;
      if (ref_dec(int'(bus0.gray_out)) !== int'(bus0.bin_out) || int'(bus0.bin_out) !== i) begin
        errors++;
        $display("FAIL loopback_%0d: decoded %0d bin_out %0d expected %0d",
                 i, ref_dec(int'(bus0.gray_out)), bus0.bin_out, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    random_traffic(600);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    init_val[0] = 0;
    init_val[1] = 14;
    rst_n     = 1'b0;
    src_sel   = 1'b0;
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_stream();
    test_backpressure();
    test_counter_wrap();
    test_cnt_clr();
    test_loopback();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
